// File: rtl/fir_pkg.sv
// Shared types and sizes for the symmetric complex FIR front end and datapath.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package fir_pkg;

  // Tap geometry: N_MULT multipliers time-shared over N_PHASE phases.
  // The 29 taps are folded into 15 coefficients by symmetry.
  localparam int N_MULT  = 5;
  localparam int N_PHASE = 3;
  localparam int N_COEF  = N_MULT * N_PHASE;
  localparam int N_TAPS  = 2 * N_COEF - 1;
  localparam int IQ_W    = 24;

  // Complex sample, I/Q signed 1.23.
  typedef struct packed {
    logic signed [IQ_W-1:0] i;
    logic signed [IQ_W-1:0] q;
  } Samp;

  // Complex coefficient, I/Q signed 1.23.
  typedef struct packed {
    logic signed [IQ_W-1:0] i;
    logic signed [IQ_W-1:0] q;
  } Coef;

  // Sequencer phase state. IDLE shares mux_sel 0 with PH0.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH0  = 2'd1,
    PH1  = 2'd2,
    PH2  = 2'd3
  } seq_state_t;

  // Datapath operand-mux select for a given sequencer state.
  function automatic logic [1:0] phase_of(seq_state_t s);
    case (s)
      PH1:     return 2'd1;
      PH2:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fir_input_sequencer_if.sv
// Bundle between the sample/coefficient source and the FIR input sequencer,
// plus the delay line, coefficient bank and phase controls it presents to
// fir_datapath. master = source/datapath side, slave = the sequencer.
// Ports: push side (PushIn, SampIn, StopIn), coefficient side (CoefWr,
// CoefAddr, CoefIn, CoefCommit), datapath side (samp, coef, mux_sel,
// partialProductAccumulate_valid, finalAccumulateRounding_en), status
// (Overflow, Busy).
interface fir_input_sequencer_if;
  import fir_pkg::*;

  // sample push
  logic                PushIn;
  Samp                 SampIn;
  logic                StopIn;

  // coefficient programming
  logic                CoefWr;
  logic [3:0]          CoefAddr;
  Coef                 CoefIn;
  logic                CoefCommit;

  // towards fir_datapath
  Samp [N_TAPS-1:0]    samp;
  Coef [N_COEF-1:0]    coef;
  logic [1:0]          mux_sel;
  logic                partialProductAccumulate_valid;
  logic                finalAccumulateRounding_en;

  // status
  logic                Overflow;
  logic                Busy;

  modport master (
    output PushIn, SampIn, CoefWr, CoefAddr, CoefIn, CoefCommit,
    input  StopIn, samp, coef, mux_sel,
           partialProductAccumulate_valid, finalAccumulateRounding_en,
           Overflow, Busy
  );

  modport slave (
    input  PushIn, SampIn, CoefWr, CoefAddr, CoefIn, CoefCommit,
    output StopIn, samp, coef, mux_sel,
           partialProductAccumulate_valid, finalAccumulateRounding_en,
           Overflow, Busy
  );

endinterface

// File: rtl/fir_in_fifo.sv
// Small synchronous FIFO holding pushed samples until the sequencer can take them.
// Latency: one cycle from push to visible at pop_dat (empty deasserts next edge).
// Backpressure: registered full; a push while full is dropped (drop strobe) unless popped same cycle.
// Ports: clk, reset (async, active-high), push/push_dat, pop/pop_dat, full, empty, drop.
module fir_in_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign pop_dat = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
    end
  end

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/fir_input_sequencer.sv
// FIR front end: buffers samples, keeps the 29-tap delay line and 15-entry coef
// banks, and sequences the 3-phase datapath control (one group every 3 cycles).
// Latency: push to PH0 in 2 cycles; final accumulate strobe MULT_LAT+4 cycles after PH0.
// Backpressure: StopIn (registered FIFO full); pushes while full are dropped and set sticky Overflow.
// Ports: clk, reset (async, active-high), bus (fir_input_sequencer_if.slave).
module fir_input_sequencer
  import fir_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int MULT_LAT   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  fir_input_sequencer_if.slave        bus
);

  // Tag pipe spans from the cycle after PH0 to the final accumulate strobe.
  localparam int TAG_DEPTH = MULT_LAT + 4;

  seq_state_t           state;
  seq_state_t           next_state;
  logic                 pop;
  logic                 issue;
  logic [1:0]           mux_sel;

  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 push_drop;
  Samp                  pop_dat;

  Samp [N_TAPS-1:0]     samp_q;
  Coef [N_COEF-1:0]     shadow_q;
  Coef [N_COEF-1:0]     shadow_nxt;
  Coef [N_COEF-1:0]     active_q;
  logic                 pending_q;
  logic                 commit_req;
  logic                 copy_bank;

  logic [TAG_DEPTH-1:0] tag_q;
  logic                 ovf_q;

  fir_in_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(Samp))
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (bus.PushIn),
    .push_dat (bus.SampIn),
    .pop      (pop),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .drop     (push_drop)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!fifo_empty) next_state = PH0;
      PH0:     next_state = PH1;
      PH1:     next_state = PH2;
      PH2:     next_state = fifo_empty ? IDLE : PH0;
      default: next_state = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // A sample is taken whenever the FSM can start a new group (IDLE or the
  // last phase of the current one), which keeps groups back-to-back.
  always_comb begin
    mux_sel = phase_of(state);
    issue   = (state == PH0);
    pop     = ((state == IDLE) || (state == PH2)) && !fifo_empty;
  end

  // ---------------- delay line ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_q <= '0;
    end else if (pop) begin
      samp_q <= {samp_q[N_TAPS-2:0], pop_dat};
    end
  end

  // ---------------- coefficient banks ----------------
  // Shadow with this cycle's write folded in, so a write alongside a commit
  // lands in the copy. Address 15 has no backing entry and is ignored.
  always_comb begin
    shadow_nxt = shadow_q;
    if (bus.CoefWr && (bus.CoefAddr <= 4'(N_COEF-1))) begin
      shadow_nxt[bus.CoefAddr] = bus.CoefIn;
    end
  end

  // The active bank may only change at a group boundary: on the edge that
  // enters PH0 (pop), or at once when fully idle (IDLE with FIFO empty; IDLE
  // with FIFO non-empty pops and therefore also enters PH0).
  assign commit_req = pending_q || bus.CoefCommit;
  assign copy_bank  = commit_req && ((state == IDLE) || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_nxt;
      if (copy_bank) active_q <= shadow_nxt;
      pending_q <= commit_req && !copy_bank;
    end
  end

  // ---------------- group tag pipe ----------------
  // tag_q[j] is set j+1 cycles after a group's PH0 cycle. Strobes are decoded
  // from fixed taps, so overlapping groups 3 cycles apart never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tag_q <= '0;
    else       tag_q <= {tag_q[TAG_DEPTH-2:0], issue};
  end

  // ---------------- overflow ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          ovf_q <= 1'b0;
    else if (push_drop) ovf_q <= 1'b1;
  end

  // ---------------- outputs ----------------
  assign bus.samp                           = samp_q;
  assign bus.coef                           = active_q;
  assign bus.mux_sel                        = mux_sel;
  assign bus.partialProductAccumulate_valid = tag_q[MULT_LAT+1] | tag_q[MULT_LAT+2];
  assign bus.finalAccumulateRounding_en     = tag_q[MULT_LAT+3];
  assign bus.StopIn                         = fifo_full;
  assign bus.Overflow                       = ovf_q;
  assign bus.Busy                           = !fifo_empty || (state != IDLE) || (|tag_q);

endmodule

// File: tb/tb_fir_input_sequencer.sv
// Self-checking bench for fir_input_sequencer: directed scenarios plus random
// traffic against a transaction-level reference model.
module tb_fir_input_sequencer;
  import fir_pkg::*;

  localparam int DEPTH = 4;
  localparam int ML    = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir_input_sequencer_if bus();

  fir_input_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .MULT_LAT   (ML)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  // Groups are described by the cycle their sample was popped; all phase and
  // strobe expectations are offsets from that cycle.
  Samp mq[$];          // samples waiting in the FIFO
  int  pops[$];        // recent pop cycles
  int  lp;             // latest pop cycle
  int  cyc;
  Samp m_samp[N_TAPS];
  Coef m_shadow[N_COEF];
  Coef m_act[N_COEF];
  bit  m_pend;
  bit  m_ovf;
  int  m_drops;
  int  fin_seen;
  Coef zc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int exp_mux(int c);
    foreach (pops[i]) begin
      if (c == pops[i] + 2) return 1;
      if (c == pops[i] + 3) return 2;
    end
    return 0;
  endfunction

  // Group PH0 is pop+1; valid at PH0+2+ML and PH0+3+ML, final at PH0+4+ML.
  function automatic bit exp_valid(int c);
    foreach (pops[i])
      if (c == pops[i] + 3 + ML || c == pops[i] + 4 + ML) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_final(int c);
    foreach (pops[i])
      if (c == pops[i] + 5 + ML) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    mq.delete();
    pops.delete();
    lp = -100;
    m_pend = 1'b0;
    m_ovf = 1'b0;
    m_drops = 0;
    foreach (m_samp[k]) m_samp[k] = '0;
    foreach (m_act[k]) begin
      m_act[k] = '0;
      m_shadow[k] = '0;
    end
  endtask

  // One clock cycle: check outputs for this cycle, drive inputs, advance model.
  task automatic step(input bit push, input Samp s, input bit cw,
                      input logic [3:0] ca, input Coef ci, input bit cc);
    bit do_pop;
    bit commit_req;
    bit copy;
    chk("mux_sel",   64'(bus.mux_sel), 64'(exp_mux(cyc)));
    chk("ppa_valid", 64'(bus.partialProductAccumulate_valid), 64'(exp_valid(cyc)));
    chk("final_en",  64'(bus.finalAccumulateRounding_en), 64'(exp_final(cyc)));
    chk("StopIn",    64'(bus.StopIn), 64'(mq.size() == DEPTH));
    chk("Overflow",  64'(bus.Overflow), 64'(m_ovf));
    chk("Busy",      64'(bus.Busy), 64'((mq.size() > 0) || (cyc <= lp + 5 + ML)));
    chk("samp0",     64'(bus.samp[0]), 64'(m_samp[0]));
    chk("coef7",     64'(bus.coef[7]), 64'(m_act[7]));
    if (bus.finalAccumulateRounding_en) fin_seen++;

    bus.PushIn     = push;
    bus.SampIn     = s;
    bus.CoefWr     = cw;
    bus.CoefAddr   = ca;
    bus.CoefIn     = ci;
    bus.CoefCommit = cc;

    // a new group may start 3 cycles after the previous one
    do_pop = (mq.size() > 0) && (cyc >= lp + 3);
    if (cw && ca != 4'd15) m_shadow[ca] = ci;
    commit_req = m_pend || cc;
    // idle (no group in its phases) or starting a group: bank may change
    copy = commit_req && (do_pop || cyc >= lp + 4);
    if (copy) m_act = m_shadow;
    m_pend = commit_req && !copy;
    if (do_pop) begin
      for (int k = N_TAPS - 1; k > 0; k--) m_samp[k] = m_samp[k-1];
      m_samp[0] = mq.pop_front();
      lp = cyc;
      pops.push_back(cyc);
      if (pops.size() > 4) pops.delete(0);
    end
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(s);
      else begin
        m_ovf = 1'b1;
        m_drops++;
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 4'd0, zc, 1'b0);
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < N_TAPS; k++)
      chk($sformatf("%s samp[%0d]", tag, k), 64'(bus.samp[k]), 64'(m_samp[k]));
    for (int k = 0; k < N_COEF; k++)
      chk($sformatf("%s coef[%0d]", tag, k), 64'(bus.coef[k]), 64'(m_act[k]));
  endtask

  // Called mid-cycle: asserts reset, checks outputs clear at once, releases
  // on the following negedge.
  task automatic do_reset();
    reset = 1'b1;
    bus.PushIn = 1'b0; bus.SampIn = '0; bus.CoefWr = 1'b0;
    bus.CoefAddr = '0; bus.CoefIn = '0; bus.CoefCommit = 1'b0;
    #1;
    chk("rst_mux_sel", 64'(bus.mux_sel), 64'd0);
    chk("rst_valid",   64'(bus.partialProductAccumulate_valid), 64'd0);
    chk("rst_final",   64'(bus.finalAccumulateRounding_en), 64'd0);
    chk("rst_StopIn",  64'(bus.StopIn), 64'd0);
    chk("rst_Overflow",64'(bus.Overflow), 64'd0);
    chk("rst_Busy",    64'(bus.Busy), 64'd0);
    chk("rst_samp0",   64'(bus.samp[0]), 64'd0);
    chk("rst_coef7",   64'(bus.coef[7]), 64'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Lone sample into an idle sequencer; p = push cycle.
  task automatic single_push(input string tag);
    Samp s;
    s.i = 24'h100000;
    s.q = '0;
    fin_seen = 0;
    step(1'b1, s, 1'b0, 4'd0, zc, 1'b0);                         // p
    idle(2); chk({tag, "_mux_p3"}, 64'(bus.mux_sel), 64'd1);      // p+3
    idle(1); chk({tag, "_mux_p4"}, 64'(bus.mux_sel), 64'd2);      // p+4
    idle(1); chk({tag, "_valid_p5"}, 64'(bus.partialProductAccumulate_valid), 64'd0);
    idle(1); chk({tag, "_valid_p6"}, 64'(bus.partialProductAccumulate_valid), 64'd1);
    idle(1); chk({tag, "_valid_p7"}, 64'(bus.partialProductAccumulate_valid), 64'd1);
    idle(1); chk({tag, "_final_p8"}, 64'(bus.finalAccumulateRounding_en), 64'd1);
    idle(6);
    chk({tag, "_final_count"}, 64'(fin_seen), 64'd1);
    chk({tag, "_samp0"}, 64'(bus.samp[0]), 64'h100000_000000);
  endtask

  Samp pv[10];
  Samp rs;
  Coef rc;
  int  npushed;
  int  guard;

  initial begin
    zc = '0;
    cyc = 0;
    fin_seen = 0;
    reset = 1'b1;
    bus.PushIn = 1'b0; bus.SampIn = '0; bus.CoefWr = 1'b0;
    bus.CoefAddr = '0; bus.CoefIn = '0; bus.CoefCommit = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();

    // --- single push latency ---
    single_push("sp");

    // --- 10 pushes honoring StopIn ---
    fin_seen = 0;
    npushed = 0;
    guard = 0;
    while (npushed < 10 && guard < 300) begin
      if (!bus.StopIn && $urandom_range(0, 3) != 0) begin
        rs.i = 24'($urandom);
        rs.q = 24'($urandom);
        pv[npushed] = rs;
        npushed++;
        step(1'b1, rs, 1'b0, 4'd0, zc, 1'b0);
      end else begin
        idle(1);
      end
      guard++;
    end
    chk("b10_pushed", 64'(npushed), 64'd10);
    idle(40);
    chk("b10_final_count", 64'(fin_seen), 64'd10);
    chk("b10_overflow", 64'(bus.Overflow), 64'd0);
    for (int k = 0; k < 10; k++)
      chk($sformatf("b10_samp[%0d]", k), 64'(bus.samp[k]), 64'(pv[9-k]));
    chk("b10_samp10", 64'(bus.samp[10]), 64'h100000_000000);
    check_all("b10");

    // --- 12 pushes every cycle, StopIn ignored ---
    do_reset();
    fin_seen = 0;
    for (int i = 0; i < 12; i++) begin
      rs.i = 24'($urandom);
      rs.q = 24'($urandom);
      step(1'b1, rs, 1'b0, 4'd0, zc, 1'b0);
    end
    idle(40);
    chk("ovf_sticky", 64'(bus.Overflow), 64'd1);
    chk("ovf_final_count", 64'(fin_seen), 64'(12 - m_drops));
    check_all("ovf");

    // --- coefficient commit during PH1 with a second group queued ---
    do_reset();
    rs.i = 24'h0ABCDE; rs.q = 24'h012345;
    step(1'b1, rs, 1'b0, 4'd0, zc, 1'b0);                        // p
    rs.i = 24'h054321; rs.q = 24'hF00001;
    step(1'b1, rs, 1'b0, 4'd0, zc, 1'b0);                        // p+1
    rc.i = 24'h7FFFFF; rc.q = 24'h7FFFFF;
    step(1'b0, '0, 1'b1, 4'd15, rc, 1'b0);                        // p+2 PH0, addr 15
    rc.i = 24'h200000; rc.q = '0;
    chk("cm_mux_ph1", 64'(bus.mux_sel), 64'd1);
    step(1'b0, '0, 1'b1, 4'd7, rc, 1'b1);                         // p+3 PH1, write+commit
    chk("cm_mux_ph2", 64'(bus.mux_sel), 64'd2);
    chk("cm_coef7_ph2_old", 64'(bus.coef[7]), 64'd0);
    idle(1);                                                      // p+5 PH0
    chk("cm_mux_ph0", 64'(bus.mux_sel), 64'd0);
    chk("cm_coef7_ph0_new", 64'(bus.coef[7]), 64'(rc));
    chk("cm_coef14_untouched", 64'(bus.coef[14]), 64'd0);
    idle(12);
    check_all("cm");

    // --- reset during PH1 of a group ---
    rs.i = 24'h111111; rs.q = 24'h222222;
    step(1'b1, rs, 1'b0, 4'd0, zc, 1'b0);
    idle(2);
    chk("rm_mux_ph1", 64'(bus.mux_sel), 64'd1);
    do_reset();
    fin_seen = 0;
    idle(15);
    chk("rm_no_final", 64'(fin_seen), 64'd0);
    single_push("rm");

    // --- random traffic ---
    do_reset();
    for (int i = 0; i < 900; i++) begin
      bit p;
      bit cw;
      bit cc;
      logic [3:0] ca;
      if (i == 450) do_reset();
      if (bus.StopIn) p = ($urandom_range(0, 9) == 0);
      else            p = ($urandom_range(0, 1) == 1);
      cw = ($urandom_range(0, 4) == 0);
      cc = ($urandom_range(0, 19) == 0);
      ca = 4'($urandom_range(0, 15));
      rs.i = 24'($urandom); rs.q = 24'($urandom);
      rc.i = 24'($urandom); rc.q = 24'($urandom);
      step(p, rs, cw, ca, rc, cc);
      if (i % 32 == 31) check_all("rnd");
    end
    idle(20);
    check_all("rnd_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
